// File: rtl/spi_slave_regif_pkg.sv
// Shared definitions for the SPI slave register-interface bridge.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package spi_slave_regif_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMD       = 3'd2,
    ST_ADDR      = 3'd3,
    ST_DATA      = 3'd4
  } state_t;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  // The same counter walks both the address and the data field, so it has
  // to be wide enough to count up to the larger of the two.
  function automatic int cnt_width(input int addr_w, input int data_w);
    int m;
    m = (addr_w > data_w) ? addr_w : data_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_slave_regif_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives edge pulses.
// Latency: 2 clk through the synchronisers; edge pulses are valid in the 3rd clk.
// Backpressure: none; pins are sampled every clk.
// Ports: clk; spien/spiclk/spidin raw pins in; en/din synced levels out;
//        sclk_rise/sclk_fall/en_rise/en_fall single-clk edge pulses out.
module spi_slave_regif_pin_sync (
  input  logic clk,
  input  logic spien,
  input  logic spiclk,
  input  logic spidin,
  output logic en,
  output logic din,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic en_rise,
  output logic en_fall
);

  // Bit order in the sync vectors: {spien, spiclk, spidin}.
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [1:0] prev;  // {spien, spiclk} one clk behind sync2

  // No reset: these are pure pipelines that refill from the pins while reset
  // is held, so a select that is already high at reset release never looks
  // like a fresh rising edge.
  always_ff @(posedge clk) begin
    sync1 <= {spien, spiclk, spidin};
    sync2 <= sync1;
    prev  <= sync2[2:1];
  end

  assign en        = sync2[2];
  assign din       = sync2[0];
  assign sclk_rise =  sync2[1] & ~prev[0];
  assign sclk_fall = ~sync2[1] &  prev[0];
  assign en_rise   =  sync2[2] & ~prev[1];
  assign en_fall   = ~sync2[2] &  prev[1];

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave to register-file bridge: R/~W bit, address, then burst data words, MSB first.
// Latency: SCLK edges act 3 clk after the pin; rdreq -> rddata 1 clk -> MISO MSB the clk after.
// Backpressure: none; the SPI master paces everything, clk must run >= 8x SCLK.
// Ports: clk, reset (sync, active high); spien/spiclk/spidin pins in, spidout/spioe out;
//        addr/wrtdata/wrt write side, rdreq/rddata read side; abort and busy status.
module spi_slave_regif
  import spi_slave_regif_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int BURST  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spien,
  input  logic              spiclk,
  input  logic              spidin,
  output logic              spidout,
  output logic              spioe,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrtdata,
  output logic              wrt,
  output logic              rdreq,
  input  logic [DATA_W-1:0] rddata,
  output logic              abort,
  output logic              busy
);

  localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic en, din, sclk_rise, sclk_fall, en_rise, en_fall;

  spi_slave_regif_pin_sync u_sync (
    .clk       (clk),
    .spien     (spien),
    .spiclk    (spiclk),
    .spidin    (spidin),
    .en        (en),
    .din       (din),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .en_rise   (en_rise),
    .en_fall   (en_fall)
  );

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              mode;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] tx;
  logic              load_tx;   // rddata is valid this clk
  logic              inc_pend;  // post-write address increment

  logic addr_done, word_done, boundary, abort_nxt;

  assign addr_done = (state == ST_ADDR) && sclk_rise && (bit_cnt == ADDR_LAST);
  assign word_done = (state == ST_DATA) && sclk_rise && (bit_cnt == DATA_LAST);
  // A select drop is clean only between words, counting a word that
  // completes in the very same clk.
  assign boundary  = word_done || ((bit_cnt == '0) && !sclk_rise);
  assign abort_nxt = busy && en_fall && !((state == ST_DATA) && boundary);

  assign busy    = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign spioe   = busy && (mode == MODE_READ) && (state == ST_DATA);
  assign spidout = spioe && tx[DATA_W-1];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_WAIT_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_IDLE: if (!en) state_nxt = ST_IDLE;
      ST_IDLE:      if (en_rise) state_nxt = ST_CMD;
      ST_CMD: begin
        if (en_fall)        state_nxt = ST_IDLE;
        else if (sclk_rise) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (en_fall)        state_nxt = ST_IDLE;
        else if (addr_done) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (en_fall)                       state_nxt = ST_IDLE;
        else if (word_done && BURST == 0)  state_nxt = ST_WAIT_IDLE;
      end
      default: state_nxt = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      mode     <= MODE_WRITE;
      rx       <= '0;
      tx       <= '0;
      addr     <= '0;
      wrtdata  <= '0;
      wrt      <= 1'b0;
      rdreq    <= 1'b0;
      abort    <= 1'b0;
      load_tx  <= 1'b0;
      inc_pend <= 1'b0;
    end else begin
      wrt      <= 1'b0;
      rdreq    <= 1'b0;
      inc_pend <= 1'b0;
      abort    <= abort_nxt;
      load_tx  <= rdreq;
      if (inc_pend) addr <= addr + 1'b1;
      if (load_tx)  tx   <= rddata;

      case (state)
        ST_IDLE: begin
          if (en_rise) begin
            bit_cnt <= '0;
            mode    <= MODE_WRITE;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            mode    <= din;
            bit_cnt <= '0;
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr    <= ADDR_W'({addr, din});
            bit_cnt <= addr_done ? '0 : bit_cnt + 1'b1;
            if (addr_done && mode == MODE_READ && !en_fall) rdreq <= 1'b1;
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            rx      <= DATA_W'({rx, din});
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            if (word_done) begin
              if (mode == MODE_WRITE) begin
                wrt     <= 1'b1;
                wrtdata <= DATA_W'({rx, din});
                if (BURST != 0 && !en_fall) inc_pend <= 1'b1;
              end else if (BURST != 0 && !en_fall) begin
                // Preload the next word of the burst.
                addr  <= addr + 1'b1;
                rdreq <= 1'b1;
              end
            end
          end
          // The fall right after a word boundary (count 0) must not shift:
          // the freshly loaded MSB has not been sampled by the master yet.
          if (sclk_fall && mode == MODE_READ && bit_cnt != '0) tx <= tx << 1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: bit-banged SPI master plus register-file responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave_regif;

  logic       clk = 1'b0;
  logic       reset;
  logic       spien, spiclk, spidin;
  logic       spidout, spioe;
  logic [3:0] addr;
  logic [7:0] wrtdata;
  logic       wrt, rdreq;
  logic [7:0] rddata;
  logic       abort, busy;

  spi_slave_regif #(.ADDR_W(4), .DATA_W(8), .BURST(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .spien   (spien),
    .spiclk  (spiclk),
    .spidin  (spidin),
    .spidout (spidout),
    .spioe   (spioe),
    .addr    (addr),
    .wrtdata (wrtdata),
    .wrt     (wrt),
    .rdreq   (rdreq),
    .rddata  (rddata),
    .abort   (abort),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Register-file contents as seen by reads.
  function automatic logic [7:0] rd_model(input logic [3:0] a);
    logic [7:0] t;
    t = {4'h0, a};
    if (a == 4'hC) return 8'h5A;
    return t * 8'd3;
  endfunction

  // Scoreboards: writes as {addr, data}, reads as addr.
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  int abort_cnt   = 0;
  int spioe_cycles = 0;
  int dout_leak   = 0;

  // Responder: rddata is valid only in the clk after rdreq, garbage otherwise.
  logic       rd_pend = 1'b0;
  logic [3:0] rd_a    = 4'h0;
  always @(negedge clk) begin
    rddata  = rd_pend ? rd_model(rd_a) : 8'($urandom);
    rd_pend = rdreq;
    rd_a    = addr;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (wrt) begin
        if (exp_wr.size() == 0) chk("wrt_unexpected", 32'd1, 32'd0);
        else begin
          logic [11:0] e;
          e = exp_wr.pop_front();
          chk("wrt_addr", 32'(addr), 32'(e[11:8]));
          chk("wrt_data", 32'(wrtdata), 32'(e[7:0]));
        end
      end
      if (rdreq) begin
        if (exp_rd.size() == 0) chk("rdreq_unexpected", 32'd1, 32'd0);
        else chk("rdreq_addr", 32'(addr), 32'(exp_rd.pop_front()));
      end
      if (abort) abort_cnt++;
      if (spioe) spioe_cycles++;
      if (!spioe && spidout) dout_leak++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic b, output logic so, output logic oe);
    spidin = b;
    clks(5);
    so = spidout;
    oe = spioe;
    spiclk = 1'b1;
    clks(5);
    spiclk = 1'b0;
  endtask

  task automatic start_frame();
    spien = 1'b1;
    clks(5);
  endtask

  task automatic end_frame();
    clks(5);
    spien = 1'b0;
    clks(10);
  endtask

  // Command bit and address; checks MISO stays disabled through the header.
  task automatic send_hdr(input logic rd, input logic [3:0] a);
    logic so, oe;
    xfer(rd, so, oe);
    chk("hdr_oe_cmd", 32'(oe), 32'd0);
    for (int i = 3; i >= 0; i--) begin
      xfer(a[i], so, oe);
      chk("hdr_oe_addr", 32'(oe), 32'd0);
    end
  endtask

  task automatic write_frame(input logic [3:0] a, input int nw, input logic [31:0] words);
    logic so, oe;
    logic [7:0] w;
    start_frame();
    send_hdr(1'b0, a);
    for (int k = 0; k < nw; k++) begin
      w = words[8*(nw-1-k) +: 8];
      exp_wr.push_back({4'(a + 4'(k)), w});
      for (int i = 7; i >= 0; i--) xfer(w[i], so, oe);
    end
    end_frame();
  endtask

  task automatic read_frame(input logic [3:0] a, input int nw);
    logic so, oe;
    logic [7:0] got, exp;
    start_frame();
    exp_rd.push_back(a);
    send_hdr(1'b1, a);
    for (int k = 0; k < nw; k++) begin
      exp_rd.push_back(4'(a + 4'(k + 1)));  // preload issued at each word end
      exp = rd_model(4'(a + 4'(k)));
      for (int i = 7; i >= 0; i--) begin
        xfer(1'b0, so, oe);
        got[i] = so;
        chk("read_oe", 32'(oe), 32'd1);
      end
      chk("miso_word", 32'(got), 32'(exp));
    end
    end_frame();
  endtask

  initial begin
    int a0, s0;
    logic so, oe;
    reset = 1'b1; spien = 1'b0; spiclk = 1'b0; spidin = 1'b0;
    clks(6);
    reset = 1'b0;
    clks(5);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_rdreq", 32'(rdreq), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_spioe", 32'(spioe), 32'd0);
    chk("rst_wrtdata", 32'(wrtdata), 32'd0);

    // Single write 0,0101,A3
    s0 = spioe_cycles;
    start_frame();
    chk("busy_in_frame", 32'(busy), 32'd1);
    send_hdr(1'b0, 4'h5);
    exp_wr.push_back({4'h5, 8'hA3});
    for (int i = 7; i >= 0; i--) xfer(~(8'h5C >> i) & 1'b1, so, oe);  // ~5C = A3
    end_frame();
    chk("write_spioe_never", 32'(spioe_cycles - s0), 32'd0);
    chk("write_busy_after", 32'(busy), 32'd0);

    // Single read at C
    read_frame(4'hC, 1);
    chk("read_spioe_after", 32'(spioe), 32'd0);
    chk("read_busy_after", 32'(busy), 32'd0);

    // Burst write from F wrapping to 0,1
    a0 = abort_cnt;
    s0 = spioe_cycles;
    write_frame(4'hF, 3, 32'h00112233);
    chk("bw_no_abort", 32'(abort_cnt - a0), 32'd0);
    chk("bw_addr_after", 32'(addr), 32'd2);
    chk("bw_spioe_never", 32'(spioe_cycles - s0), 32'd0);

    // Burst read from E
    read_frame(4'hE, 3);
    chk("br_addr_after", 32'(addr), 32'd1);

    // Abort after 6 data bits
    a0 = abort_cnt;
    start_frame();
    send_hdr(1'b0, 4'h6);
    for (int i = 0; i < 6; i++) xfer(1'b1, so, oe);
    end_frame();
    chk("abort_pulse", 32'(abort_cnt - a0), 32'd1);
    write_frame(4'h9, 1, 32'h3C);
    chk("post_abort_no_abort", 32'(abort_cnt - a0), 32'd1);

    // Reset mid-frame with spien held, then SCLK keeps running
    a0 = abort_cnt;
    start_frame();
    send_hdr(1'b0, 4'h3);
    for (int i = 0; i < 3; i++) xfer(1'b1, so, oe);
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(2);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    for (int i = 0; i < 13; i++) xfer(i[0], so, oe);
    chk("midrst_busy_held", 32'(busy), 32'd0);
    end_frame();
    chk("midrst_no_abort", 32'(abort_cnt - a0), 32'd0);
    write_frame(4'h7, 1, 32'h5C);
    read_frame(4'h2, 1);

    clks(10);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("dout_gated", 32'(dout_leak), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
